// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory and hands each returned word, with its PC, to the decoder.
// Redirects restart fetch and squash any response still in flight.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redir_pc;

  assign redir_pc       = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = (state_q == StReq) && !rst;
  assign imem_req_addr  = {pc_q[31:2], 2'b00};
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  // Next-state logic for the fetch FSM, PC and the held instruction.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    unique case (state_q)
      StReq: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end
        if (imem_req_ready) begin
          state_d = StWait;
          // The accepted request was for the old PC, so its data is stale.
          drop_d  = redirect_valid;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
            if (redirect_valid) begin
              pc_d = redir_pc;
            end
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = StHold;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end
      StHold: begin
        // Redirect wins over the decoder handshake; either way the slot empties.
        if (redirect_valid || inst_ready) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          state_d      = StReq;
          if (redirect_valid) begin
            pc_d = redir_pc;
          end
        end
      end
      default: state_d = StReq;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: two instances (reset PC 0 and 32'hFFFF_FFFC) share one
// directed stimulus stream; a transaction-level model checks every cycle and
// literal expectations pin the interesting points of the sequence.
module tb_inst_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready, imem_rsp_valid, redirect_valid, inst_ready;
  logic [31:0] imem_rsp_data, redirect_pc;

  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic        iv        [2];
  logic [31:0] ins       [2];
  logic [31:0] ipc       [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(Nop)) u_dut0 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid[0]), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr[0]),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(iv[0]), .inst_ready(inst_ready), .inst(ins[0]), .inst_pc(ipc[0])
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(Nop)) u_dut1 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid[1]), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr[1]),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(iv[1]), .inst_ready(inst_ready), .inst(ins[1]), .inst_pc(ipc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Transaction model: outstanding/stale request counts, next PC, held slot.
  int          n_out   [2];
  int          n_stale [2];
  logic        m_have  [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_inst  [2];
  logic [31:0] m_ipc   [2];
  bit          started = 0;

  initial begin
    bit can_req;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          n_out[i]   = 0;
          n_stale[i] = 0;
          m_have[i]  = 1'b0;
          m_pc[i]    = (i == 0) ? 32'h0 : 32'hFFFF_FFFC;
          m_inst[i]  = Nop;
          m_ipc[i]   = 32'h0;
          started    = 1;
        end else if (started) begin
          can_req = (n_out[i] == 0) && !m_have[i];
          if (m_have[i] && (redirect_valid || inst_ready)) begin
            m_have[i] = 1'b0;
            m_inst[i] = Nop;
          end
          if (imem_rsp_valid && n_out[i] > 0) begin
            n_out[i]--;
            if (n_stale[i] > 0) n_stale[i]--;
            else if (!redirect_valid) begin
              m_have[i] = 1'b1;
              m_inst[i] = imem_rsp_data;
              m_ipc[i]  = m_pc[i];
              m_pc[i]   = m_pc[i] + 32'd4;
            end
          end
          if (can_req && imem_req_ready) n_out[i]++;
          if (redirect_valid) begin
            n_stale[i] = n_out[i];
            m_pc[i]    = redirect_pc & 32'hFFFF_FFFC;
          end
        end
      end
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 2; i++) begin
          chk("m_req_valid", {31'b0, req_valid[i]},
              {31'b0, !rst && n_out[i] == 0 && !m_have[i]});
          chk("m_req_addr", req_addr[i], m_pc[i]);
          chk("m_inst_valid", {31'b0, iv[i]}, {31'b0, m_have[i]});
          chk("m_inst", ins[i], m_inst[i]);
          chk("m_inst_pc", ipc[i], m_ipc[i]);
        end
      end
    end
  end

  // Drive one cycle of inputs just after an edge, then advance past the next edge.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] d,
                      input logic redir, input logic [31:0] rpc, input logic ir);
    rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
    redirect_valid = redir; redirect_pc = rpc; inst_ready = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ir);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ir);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0; #1;
    // Basic fetch
    chk("rst_inst_valid", {31'b0, iv[0]}, 32'h0);
    chk("rst_inst", ins[0], Nop);
    chk("first_addr", req_addr[0], 32'h0);
    chk("first_req_valid", {31'b0, req_valid[0]}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b1);
    chk("t1_inst", ins[0], 32'h0050_0093);
    chk("t1_inst_pc", ipc[0], 32'h0);
    chk("wrap_inst_pc", ipc[1], 32'hFFFF_FFFC);
    idle(1'b1);
    chk("t1_next_addr", req_addr[0], 32'h4);
    chk("wrap_next_addr", req_addr[1], 32'h0);
    // Decoder stall
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0020_81B3, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      chk("stall_inst", ins[0], 32'h0020_81B3);
      chk("stall_inst_pc", ipc[0], 32'h4);
      chk("stall_req_valid", {31'b0, req_valid[0]}, 32'h0);
    end
    idle(1'b1);
    chk("stall_release_req", {31'b0, req_valid[0]}, 32'h1);
    chk("stall_release_addr", req_addr[0], 32'h8);
    // Redirect while waiting
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    chk("wait_redir_valid", {31'b0, iv[0]}, 32'h0);
    chk("wait_redir_addr", req_addr[0], 32'h100);
    // Redirect coincident with response
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h203, 1'b0);
    chk("coinc_valid", {31'b0, iv[0]}, 32'h0);
    chk("coinc_addr", req_addr[0], 32'h200);
    // Redirect in HOLD with inst_ready
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    chk("hold_inst_pc", ipc[0], 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    chk("hold_redir_valid", {31'b0, iv[0]}, 32'h0);
    chk("hold_redir_inst", ins[0], Nop);
    chk("hold_redir_addr", req_addr[0], 32'h300);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
    chk("after_redir_inst", ins[0], 32'h2222_2222);
    chk("after_redir_pc", ipc[0], 32'h300);
    idle(1'b1);
    // Redirect in REQ, with and without acceptance
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
    chk("req_redir_acc_valid", {31'b0, iv[0]}, 32'h0);
    chk("req_redir_acc_addr", req_addr[0], 32'h400);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    chk("req_redir_addr", req_addr[0], 32'h500);
    // Reset in the middle of a fetch
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("midrst_req_valid", {31'b0, req_valid[1]}, 32'h0);
    chk("midrst_inst", ins[1], Nop);
    chk("midrst_inst_pc", ipc[1], 32'h0);
    idle(1'b0);
    chk("midrst_req_valid_after", {31'b0, req_valid[1]}, 32'h1);
    chk("midrst_addr", req_addr[1], 32'hFFFF_FFFC);
    chk("midrst_addr0", req_addr[0], 32'h0);
    // One best-case fetch after reset
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b1);
    chk("final_inst", ins[1], 32'h0010_0113);
    idle(1'b1);
    idle(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
